// File: rtl/adder_seq_pkg.sv
// Shared definitions for the adder sequencer: FSM encoding, window-size codes
// and the number of multiplier rounds per (window size, stride).
`timescale 1ns/1ps
package adder_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [3:0] W3 = 4'd0;
  localparam logic [3:0] W5 = 4'd1;
  localparam logic [3:0] W7 = 4'd2;

  // Beats needed to stream one window through the adder.
  function automatic logic [2:0] rounds(input logic [3:0] ws, input logic st);
    case (ws)
      W5:      rounds = st ? 3'd1 : 3'd2;
      W7:      rounds = st ? 3'd2 : 3'd4;
      default: rounds = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/adder_seq.sv
// Sequences multiplier results into the adder one round per beat, then waits
// for the adder's Psum strobe (or a timeout) before accepting the next window.
`timescale 1ns/1ps
module adder_seq
  import adder_seq_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_wsize,
  input  logic       cmd_stride,
  input  logic       src_valid,
  output logic       MUL_DATA_valid,
  output logic [3:0] wsize,
  output logic       stride,
  output logic [2:0] wround,
  input  logic       Psum_valid,
  output logic       done,
  output logic       err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state;
  logic [CW-1:0] wcnt;
  logic          psum_seen;
  logic [2:0]    last_round;

  assign cmd_ready      = (state == IDLE);
  assign MUL_DATA_valid = (state == ISSUE) && src_valid;
  assign last_round     = rounds(wsize, stride) - 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wsize     <= '0;
      stride    <= 1'b0;
      wround    <= '0;
      wcnt      <= '0;
      psum_seen <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          if (cmd_wsize <= W7) begin
            wsize     <= cmd_wsize;
            stride    <= cmd_stride;
            wround    <= '0;
            wcnt      <= '0;
            psum_seen <= 1'b0;
            state     <= ISSUE;
          end else begin
            err <= 1'b1;
          end
        end
        ISSUE: begin
          // An early Psum (up to and including the last beat) is remembered.
          if (Psum_valid) psum_seen <= 1'b1;
          if (src_valid) begin
            if (wround == last_round) state  <= WAIT;
            else                      wround <= wround + 3'd1;
          end
        end
        WAIT: begin
          // Psum wins over a timeout landing on the same cycle.
          if (psum_seen || Psum_valid) begin
            done  <= 1'b1;
            state <= IDLE;
          end else if (wcnt == CW'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_seq.sv
// Randomized and directed checks of adder_seq against a cycle-index reference
// computed from the round table and the Psum/timeout rules.
`timescale 1ns/1ps
module tb_adder_seq;

  localparam int TO = 16;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_stride = 1'b0, src_valid = 1'b0, Psum_valid = 1'b0;
  logic [3:0] cmd_wsize = '0;
  logic       cmd_ready, MUL_DATA_valid, stride, done, err;
  logic [3:0] wsize;
  logic [2:0] wround;

  int nchk = 0, nerr = 0;
  bit pat[64];
  int rtab[2][3] = '{'{1, 2, 4}, '{1, 1, 2}};

  always #5 clk = ~clk;

  adder_seq #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wsize(cmd_wsize), .cmd_stride(cmd_stride),
    .src_valid(src_valid), .MUL_DATA_valid(MUL_DATA_valid),
    .wsize(wsize), .stride(stride), .wround(wround),
    .Psum_valid(Psum_valid), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: Psum during ISSUE; 1: Psum k cycles after WAIT entry; 2: no Psum.
  task automatic run_cmd(input logic [3:0] ws, input bit st, input int mode,
                         input int k, input bit use_pat);
    int n, lb, ones, wentry, pcyc, e;
    bit tmo;
    cmd_valid = 1; cmd_wsize = ws; cmd_stride = st;
    src_valid = 1'($urandom_range(0, 1)); Psum_valid = 0;
    @(negedge clk);
    chk("ready_idle", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 0; cmd_wsize = 4'($urandom); cmd_stride = 1'($urandom);
    if (ws > 4'd2) begin
      src_valid = 1;
      @(negedge clk);
      chk("ill_err", err, 1); chk("ill_done", done, 0);
      chk("ill_mdv", MUL_DATA_valid, 0); chk("ill_ready", cmd_ready, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("ill_err_clr", err, 0); chk("ill_mdv2", MUL_DATA_valid, 0);
      chk("ill_ready2", cmd_ready, 1);
      @(posedge clk); #1;
      src_valid = 0;
      return;
    end
    n = rtab[int'(st)][int'(ws)];
    if (!use_pat) begin
      foreach (pat[i]) pat[i] = ($urandom_range(0, 99) < 60);
      for (int i = 56; i < 64; i++) pat[i] = 1;
    end
    ones = 0; lb = -1;
    for (int i = 0; i < 64 && lb < 0; i++)
      if (pat[i]) begin ones++; if (ones == n) lb = i; end
    wentry = lb + 1;
    tmo = 0;
    case (mode)
      0:       begin pcyc = $urandom_range(0, lb); e = wentry + 1; end
      1:       begin pcyc = wentry + k; e = wentry + k + 1; end
      default: begin pcyc = -1; e = wentry + TO; tmo = 1; end
    endcase
    ones = 0;
    for (int c = 0; c <= e + 1; c++) begin
      src_valid  = (c <= lb) ? pat[c] : 1'($urandom_range(0, 1));
      Psum_valid = (c == pcyc);
      @(negedge clk);
      chk("mdv", MUL_DATA_valid, 32'((c <= lb) && src_valid));
      chk("wround", wround, (ones < n) ? ones : n - 1);
      chk("wsize", wsize, ws);
      chk("stride", stride, st);
      chk("done", done, 32'((c == e) && !tmo));
      chk("err", err, 32'((c == e) && tmo));
      chk("ready", cmd_ready, 32'(c >= e));
      if (c <= lb && src_valid) ones++;
      @(posedge clk); #1;
    end
    src_valid = 0; Psum_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    chk("rst_ready", cmd_ready, 1); chk("rst_mdv", MUL_DATA_valid, 0);
    chk("rst_wsize", wsize, 0); chk("rst_stride", stride, 0);
    chk("rst_wround", wround, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);

    // 3x3 s1-equivalent: one beat, Psum three cycles after the beat.
    foreach (pat[i]) pat[i] = 1;
    run_cmd(4'd0, 1'b0, 1, 2, 1'b1);
    // 7x7 with gaps 1,0,1,1,0,1.
    foreach (pat[i]) pat[i] = 1;
    pat[1] = 0; pat[4] = 0;
    run_cmd(4'd2, 1'b0, 1, 1, 1'b1);
    run_cmd(4'd1, 1'b1, 0, 0, 1'b0);
    run_cmd(4'd2, 1'b1, 0, 0, 1'b0);
    run_cmd(4'd3, 1'b0, 0, 0, 1'b0);
    run_cmd(4'd1, 1'b0, 2, 0, 1'b0);
    run_cmd(4'd0, 1'b0, 1, TO - 1, 1'b0);

    // Reset during the second beat of a 7x7 command.
    cmd_valid = 1; cmd_wsize = 4'd2; cmd_stride = 0;
    @(posedge clk); #1;
    cmd_valid = 0; src_valid = 1;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("ar_mdv", MUL_DATA_valid, 0); chk("ar_wround", wround, 0);
    chk("ar_wsize", wsize, 0); chk("ar_stride", stride, 0);
    chk("ar_done", done, 0); chk("ar_err", err, 0);
    @(negedge clk); rst_n = 1; src_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ar_post_done", done, 0); chk("ar_post_err", err, 0);
      chk("ar_post_ready", cmd_ready, 1);
    end
    @(posedge clk); #1;
    foreach (pat[i]) pat[i] = 1;
    run_cmd(4'd0, 1'b0, 1, 0, 1'b1);

    for (int t = 0; t < 30; t++) begin
      logic [3:0] ws;
      ws = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(3, 15)) : 4'($urandom_range(0, 2));
      run_cmd(ws, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, TO - 1), 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/adder_seq.md
ADDER_SEQ -- requirements
Module: adder_seq

Interface
REQ-001 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port cmd_valid  input  1  a new window command is presented.
REQ-004 SHALL have port cmd_ready  output  1  command accepted when cmd_valid&&cmd_ready.
REQ-005 SHALL have port cmd_wsize  input  4  0=3x3, 1=5x5, 2=7x7, others illegal.
REQ-006 SHALL have port cmd_stride  input  1  0=stride 1, 1=stride 2.
REQ-007 SHALL have port src_valid  input  1  multiplier array has the current round's MUL_results on the bus.
REQ-008 SHALL have port MUL_DATA_valid  output  1  beat issued to ADDER; doubles as src_ready.
REQ-009 SHALL have port wsize  output  4  latched cmd_wsize, to ADDER.
REQ-010 SHALL have port stride  output  1  latched cmd_stride, to ADDER.
REQ-011 SHALL have port wround  output  3  round index of the current beat, to ADDER.
REQ-012 SHALL have port Psum_valid  input  1  ADDER result strobe.
REQ-013 SHALL have port done  output  1  one-cycle pulse, command completed.
REQ-014 SHALL have port err  output  1  one-cycle pulse: illegal wsize or Psum timeout.
REQ-015 SHALL have parameter TIMEOUT, default 255, max cycles in WAIT.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, with DONE/ERR signalled by pulses on the transition back to IDLE.
REQ-017 cmd_ready SHALL be 1 only in IDLE.
REQ-018 On an accepted command with wsize<=2, the block SHALL latch wsize/stride, clear wround, and enter ISSUE next cycle.
REQ-019 On an accepted command with wsize>2, the block SHALL pulse err the next cycle and remain IDLE with no beats issued.
REQ-020 Round count SHALL be stride0: 3x3=1, 5x5=2, 7x7=4; stride1: 3x3=1, 5x5=1, 7x7=2.
REQ-021 In ISSUE, MUL_DATA_valid SHALL equal src_valid (combinational); each cycle with MUL_DATA_valid=1 is one beat.
REQ-022 wround SHALL increment after each beat except the last; gaps with src_valid=0 SHALL hold wround.
REQ-023 After the last beat the FSM SHALL enter WAIT, and wround SHALL hold its final value.
REQ-024 In WAIT, Psum_valid SHALL cause a done pulse the next cycle and return to IDLE.
REQ-025 Psum_valid arriving in ISSUE on the last-beat cycle or earlier SHALL be recorded and SHALL complete the command on entering WAIT (done 1 cycle after WAIT entry).
REQ-026 The WAIT cycle counter SHALL reach TIMEOUT without Psum_valid, then pulse err and return to IDLE.
REQ-027 Psum_valid in IDLE SHALL be ignored.
REQ-028 wsize, stride and wround SHALL stay stable from command accept until return to IDLE.
REQ-029 done and err SHALL never both be 1.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, with cmd_ready=1 after release and MUL_DATA_valid=0, wsize=0, stride=0, wround=0, done=0, err=0, and all counters cleared.
REQ-031 Reset mid-ISSUE or mid-WAIT SHALL abandon the command with no done/err pulse.

Structure
REQ-032 The shared package SHALL hold the FSM state encoding, the wsize codes (W3/W5/W7), and the rounds-per-(wsize,stride) function.
REQ-033 The block SHALL have no sub-modules; the timeout counter is inline.

Verification
REQ-034 3x3, stride 0, src_valid held 1: exactly 1 beat with wround=0, then Psum_valid 3 cycles later -> done 1 cycle after Psum_valid, cmd_ready=1 the cycle after that.
REQ-035 7x7, stride 0, src_valid toggling 1,0,1,1,0,1: 4 beats with wround 0,1,2,3, and wround holds during gaps.
REQ-036 5x5, stride 1 -> 1 beat (wround=0); 7x7, stride 1 -> 2 beats (wround 0,1).
REQ-037 wsize=3 command -> err pulse, no MUL_DATA_valid, cmd_ready stays 1.
REQ-038 5x5 with no Psum_valid, TIMEOUT=16 -> err exactly 16 cycles after WAIT entry, then IDLE.
REQ-039 rst_n pulled low during the second beat of a 7x7 command -> all outputs 0 at once, no done/err, and a new 3x3 command then completes normally.
